tap_input_conditioner: RTL
==========================

TAP_INPUT_CONDITIONER -- requirements
Module: tap_input_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive cycles a synchronized input must hold a new value before it is accepted; legal range 1..65535.
REQ-002 The block SHALL have parameter NUM_HOLES, default 8: number of button channels.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port btn_raw, input, NUM_HOLES bits: asynchronous, bouncy push-button levels, bit i = hole i.
REQ-006 The block SHALL have port pause, input, 1 bit: synchronous; when high, tap pulses are suppressed.
REQ-007 The block SHALL have port tap, output, NUM_HOLES bits: one-cycle press pulses, the direct input of the game core's tap port.
REQ-008 The block SHALL have port tap_level, output, NUM_HOLES bits: debounced button levels.
REQ-009 The block SHALL have port any_tap, output, 1 bit: OR-reduction of tap, registered in the same cycle as tap.

Function
REQ-010 Each btn_raw bit SHALL pass through a 2-flop synchronizer (sync2) before any other logic.
REQ-011 Per channel: while sync2 equals tap_level, the debounce counter SHALL be held at 0; while it differs, the counter SHALL increment once per cycle.
REQ-012 tap_level[i] SHALL take the sync2 value at the edge where the counter is DEBOUNCE_CYCLES-1 and sync2 still differs; the counter SHALL return to 0 at that edge.
REQ-013 Any cycle in which sync2 returns to tap_level before acceptance SHALL clear the counter (a bounce restarts the count).
REQ-014 tap[i] SHALL be high for exactly one cycle, registered at the same edge where tap_level[i] rises 0->1, provided pause is low in that cycle; tap SHALL never assert on a 1->0 transition.
REQ-015 Latency: if btn_raw[i] is high and stable from the edge counted as edge 1, tap[i] SHALL be high in the cycle after edge 2+DEBOUNCE_CYCLES.
REQ-016 Holding a button SHALL produce only one pulse; a new pulse requires tap_level to fall and then rise again.
REQ-017 Rising edges accepted while pause is high SHALL be discarded, not deferred; debouncing and tap_level SHALL continue during pause.
REQ-018 Simultaneous accepted rising edges on several channels SHALL all pulse in the same cycle, unless modified by REQ-022.
REQ-019 The counter SHALL saturate-free wrap never occur: its width SHALL be sized to hold DEBOUNCE_CYCLES-1.

Reset
REQ-020 While reset is high, the synchronizers, counters, tap_level, tap and any_tap SHALL all be 0 at the next edge; reset overrides pause and btn_raw.
REQ-021 Reset mid-debounce SHALL discard the partial count; a button held through reset release SHALL produce one pulse at full latency (REQ-015) measured from the first post-reset edge.

Configuration
REQ-022 With macro TAP_ONEHOT_EN defined, when more than one channel would pulse in a cycle, only the lowest-index channel SHALL pulse; the others are dropped (tap_level still updates). Without TAP_ONEHOT_EN, behaviour SHALL be per REQ-018.

Structure
REQ-023 Package tap_pkg SHALL hold NUM_HOLES (8) and DEFAULT_DEBOUNCE_CYCLES (4) constants shared with the game core and benches.
REQ-024 Per-channel synchronizer, counter and level logic SHALL live in sub-module tap_debounce_ch, instantiated NUM_HOLES times; the pulse gating, one-hot filter and any_tap logic SHALL live in the top level.

Verification (DEBOUNCE_CYCLES=4)
REQ-025 Scenario 1: btn_raw=8'h01 is held from edge 1 -> tap=8'h01 and any_tap=1 for exactly the cycle after edge 6, tap_level[0]=1 from then on, and there is no further pulse while the button is held.
REQ-026 Scenario 2: btn_raw[3] bounces 1,0,1,1,0 and then is held high -> no pulse until 4 consecutive high sync2 samples, then exactly one tap=8'h08.
REQ-027 Scenario 3: pause=1 while btn_raw[5] rises and is accepted, and pause is then dropped while the button is held -> tap stays 0 throughout and tap_level[5]=1.
REQ-028 Scenario 4: btn_raw=8'h14 rises in one cycle -> tap=8'h14 without TAP_ONEHOT_EN, tap=8'h04 with it.
REQ-029 Scenario 5: reset is asserted 2 cycles into debounce of btn_raw[7] held high -> all outputs are 0 during reset, and tap=8'h80 occurs in the cycle after the 6th post-reset edge.
REQ-030 Scenario 6: the button is released and re-pressed after tap_level falls -> a second one-cycle pulse occurs; a release shorter than 4 cycles produces no second pulse.

Source files
------------

// File: rtl/tap_pkg.sv
// rtl/tap_pkg.sv - constants shared by the tap conditioner, the game core and benches
package tap_pkg;

  localparam int NUM_HOLES = 8;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

  // Counter only has to reach cycles-1; a single-cycle debounce still needs one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/tap_debounce_ch.sv
// rtl/tap_debounce_ch.sv - one button channel: 2-flop synchronizer, debounce counter, level
module tap_debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);
  import tap_pkg::*;

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  assign accept = (sync2 != level) && (cnt == CNT_MAX);
  // High exactly on the edge where level goes 0->1; the top registers it into tap.
  assign rise   = accept && sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (accept) begin
        cnt   <= '0;
        level <= sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/tap_input_conditioner.sv
// rtl/tap_input_conditioner.sv - debounced buttons to one-cycle tap pulses
// Define TAP_ONEHOT_EN to let only the lowest-index channel pulse when several coincide.
module tap_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = tap_pkg::DEFAULT_DEBOUNCE_CYCLES,
  parameter int NUM_HOLES       = tap_pkg::NUM_HOLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_HOLES-1:0] btn_raw,
  input  logic                 pause,
  output logic [NUM_HOLES-1:0] tap,
  output logic [NUM_HOLES-1:0] tap_level,
  output logic                 any_tap
);

  logic [NUM_HOLES-1:0] rise;
  logic [NUM_HOLES-1:0] gated;
  logic [NUM_HOLES-1:0] pulse;

  for (genvar i = 0; i < NUM_HOLES; i++) begin : g_ch
    tap_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .raw  (btn_raw[i]),
      .level(tap_level[i]),
      .rise (rise[i])
    );
  end

  // Edges accepted during pause are dropped outright, never queued.
  always_comb begin
    gated = pause ? '0 : rise;
`ifdef TAP_ONEHOT_EN
    pulse = gated & (~gated + NUM_HOLES'(1));
`else
    pulse = gated;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tap     <= '0;
      any_tap <= 1'b0;
    end else begin
      tap     <= pulse;
      any_tap <= |pulse;
    end
  end

endmodule
